// File: rtl/bus_pkg.sv
// Shared definitions for the processor data-bus controller: memory map,
// region encoding, STATUS word layout and the address decoder.
package bus_pkg;

  localparam int unsigned RAM_BYTES_LOG2 = 12;
  localparam logic [31:0] ADDR_LED       = 32'h0000_1000;
  localparam logic [31:0] ADDR_SW        = 32'h0000_1004;
  localparam logic [31:0] ADDR_FIFO      = 32'h0000_1008;
  localparam logic [31:0] ADDR_STATUS    = 32'h0000_100C;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_LED,
    RGN_SW,
    RGN_FIFO,
    RGN_STATUS,
    RGN_NONE
  } region_e;

  // STATUS word bit positions
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_CNT_LSB = 2;
  localparam int unsigned ST_CNT_W   = 5;
  localparam int unsigned ST_OVF     = 8;

  // Map a byte address onto its bus region
  function automatic region_e decode_region(input logic [31:0] a);
    region_e r;
    if (a[31:RAM_BYTES_LOG2] == '0) r = RGN_RAM;
    else if (a == ADDR_LED)         r = RGN_LED;
    else if (a == ADDR_SW)          r = RGN_SW;
    else if (a == ADDR_FIFO)        r = RGN_FIFO;
    else if (a == ADDR_STATUS)      r = RGN_STATUS;
    else                            r = RGN_NONE;
    return r;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Power-of-two circular FIFO for outgoing samples.
// Ports: clk, reset (async, active-low), push/wdata in, pop in,
//        head (current front word), full, empty, count.
// A push while full is accepted only if a pop happens in the same cycle.
module sample_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [31:0]                wdata,
  input  logic                       pop,
  output logic [31:0]                head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-bus controller between a processor memory stage and its peripherals:
// external sync RAM, LED register, synchronized switches, an output sample
// FIFO and a STATUS register.
// Ports: clk, reset (async, active-low); processor side mem_we/addr/wdata/
//        rdata; RAM side ram_addr/ram_we/ram_wdata/ram_rdata; leds,
//        switches; sample stream out_valid/out_data/out_ready.
module data_bus_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RAM_AW     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [7:0]        leds,
  input  logic [2:0]        switches,
  output logic              out_valid,
  output logic [31:0]       out_data,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  region_e          region;
  region_e          sel_q;
  logic [31:0]      snap_d;
  logic [31:0]      snap_q;
  logic [31:0]      status_word;
  logic [2:0]       sw_meta;
  logic [2:0]       sw_sync;
  logic             overflow;
  logic             fifo_store;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             ovf_set;
  logic             ovf_clr;

  assign region = decode_region(addr);

  // RAM port is a straight pass-through
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_we    = mem_we && (region == RGN_RAM);
  assign ram_wdata = wdata;

  assign fifo_store = mem_we && (region == RGN_FIFO);
  assign fifo_pop   = out_valid && out_ready;
  assign out_valid  = !fifo_empty;
  assign ovf_set    = fifo_store && fifo_full && !fifo_pop;
  assign ovf_clr    = mem_we && (region == RGN_STATUS) && wdata[ST_OVF];

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_store),
    .wdata (wdata),
    .pop   (fifo_pop),
    .head  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STATUS word assembly
  always_comb begin
    status_word                            = '0;
    status_word[ST_FULL]                   = fifo_full;
    status_word[ST_EMPTY]                  = fifo_empty;
    status_word[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
    status_word[ST_OVF]                    = overflow;
  end

  // Read snapshot uses pre-store register values
  always_comb begin
    snap_d = '0;
    case (region)
      RGN_LED:    snap_d = {24'h0, leds};
      RGN_SW:     snap_d = {29'h0, sw_sync};
      RGN_STATUS: snap_d = status_word;
      default:    snap_d = '0;
    endcase
  end

  // Registers: LEDs, overflow, switch synchronizer, read select/snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds     <= '0;
      overflow <= 1'b0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      sel_q    <= RGN_NONE;
      snap_q   <= '0;
    end else begin
      if (mem_we && (region == RGN_LED)) leds <= wdata[7:0];
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      sw_meta <= switches;
      sw_sync <= sw_meta;
      sel_q   <= region;
      snap_q  <= snap_d;
    end
  end

  // RAM data arrives one cycle after the address, aligned with sel_q
  assign rdata = (sel_q == RGN_RAM) ? ram_rdata : snap_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl: directed vector table, hand-written
// FIFO/reset sequences, and randomized traffic against a behavioural model.
module tb_data_bus_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [7:0]  leds;
  logic [2:0]  switches = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;

  data_bus_ctrl #(.FIFO_DEPTH(DEPTH), .RAM_AW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_we    (mem_we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .leds      (leds),
    .switches  (switches),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // External synchronous RAM, read-before-write
  logic [31:0] bram [1024];
  logic        bram_ready = 1'b0;
  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < 1024; i++) bram[i] <= '0;
      bram_ready <= 1'b1;
    end else begin
      if (ram_we) bram[ram_addr] <= ram_wdata;
      ram_rdata <= bram[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  logic [31:0] mq[$];
  logic [7:0]  m_leds;
  logic        m_ovf;
  logic [2:0]  m_sw1, m_sw2;
  logic [31:0] m_rdata;
  logic [31:0] m_ram [1024];

  function automatic logic [31:0] m_status();
    int v;
    v = 0;
    if (m_ovf) v += 256;
    v += mq.size() * 4;
    if (mq.size() == 0) v += 2;
    if (mq.size() == DEPTH) v += 1;
    return 32'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_leds  = '0;
    m_ovf   = 1'b0;
    m_sw1   = '0;
    m_sw2   = '0;
    m_rdata = '0;
  endtask

  // Apply inputs just after an edge and check the combinational outputs
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    mem_we = we; addr = a; wdata = wd; out_ready = rdy;
    #1;
    check("ram_we", 32'(ram_we), 32'(we && (a < 32'h1000)));
    check("ram_addr", 32'(ram_addr), (a >> 2) & 32'h3FF);
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
  endtask

  // Clock once, advance the model with the held inputs, check registers
  task automatic clock();
    bit is_ram, is_led, is_sw, is_fifo, is_st, pop, full_before;
    int widx;
    @(posedge clk);
    is_ram  = addr < 32'h1000;
    is_led  = addr == 32'h1000;
    is_sw   = addr == 32'h1004;
    is_fifo = addr == 32'h1008;
    is_st   = addr == 32'h100C;
    widx    = int'((addr >> 2) & 32'h3FF);
    if (is_ram)      m_rdata = m_ram[widx];
    else if (is_led) m_rdata = {24'h0, m_leds};
    else if (is_sw)  m_rdata = {29'h0, m_sw2};
    else if (is_st)  m_rdata = m_status();
    else             m_rdata = '0;
    pop = (mq.size() != 0) && out_ready;
    full_before = mq.size() == DEPTH;
    if (pop) void'(mq.pop_front());
    if (mem_we && is_fifo) begin
      if (!full_before || pop) mq.push_back(wdata);
      else m_ovf = 1'b1;
    end
    if (mem_we && is_st && wdata[8]) m_ovf = 1'b0;
    if (mem_we && is_led) m_leds = wdata[7:0];
    if (mem_we && is_ram) m_ram[widx] = wdata;
    m_sw2 = m_sw1;
    m_sw1 = switches;
    #1;
    check("leds", 32'(leds), 32'(m_leds));
    check("rdata", rdata, m_rdata);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_ram_we;
    logic [9:0]  exp_ram_addr;
    logic [7:0]  exp_leds;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] exp40 [8];
    logic [31:0] a;
    int sel;

    for (int i = 0; i < 1024; i++) m_ram[i] = '0;
    model_reset();
    switches = 3'b101;
    @(posedge clk);
    #1;
    do_reset();

    // Directed vectors: LED, switch, RAM, unmapped and STATUS reads
    tbl[0] = '{1'b1, 32'h0000_1000, 32'h0000_00A5, 1'b0, 10'h000, 8'hA5, 32'h0000_0000};
    tbl[1] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 1'b0, 10'h000, 8'hA5, 32'h0000_00A5};
    tbl[2] = '{1'b0, 32'h0000_1004, 32'h0000_0000, 1'b0, 10'h001, 8'hA5, 32'h0000_0005};
    tbl[3] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 10'h004, 8'hA5, 32'h0000_0000};
    tbl[4] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 10'h004, 8'hA5, 32'hDEAD_BEEF};
    tbl[5] = '{1'b0, 32'h0000_2000, 32'h0000_0000, 1'b0, 10'h000, 8'hA5, 32'h0000_0000};
    tbl[6] = '{1'b0, 32'h0000_100C, 32'h0000_0000, 1'b0, 10'h003, 8'hA5, 32'h0000_0002};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].we, tbl[i].a, tbl[i].wd, 1'b0);
      check("vec_ram_we", 32'(ram_we), 32'(tbl[i].exp_ram_we));
      check("vec_ram_addr", 32'(ram_addr), 32'(tbl[i].exp_ram_addr));
      clock();
      check("vec_leds", 32'(leds), 32'(tbl[i].exp_leds));
      check("vec_rdata", rdata, tbl[i].exp_rdata);
    end

    // Fill past full with the sink stalled, then drain
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 32'h1008, 32'(i), 1'b0);
      clock();
    end
    drive(1'b0, 32'h100C, 32'h0, 1'b0);
    clock();
    check("status_full_ovf", rdata, 32'h0000_0121);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 32'h2000, 32'h0, 1'b1);
      check("drain_seq", out_data, 32'(i));
      clock();
    end
    drive(1'b0, 32'h100C, 32'h0, 1'b0);
    clock();
    check("status_drained", rdata, 32'h0000_0102);
    drive(1'b1, 32'h100C, 32'h100, 1'b0);
    clock();
    drive(1'b0, 32'h100C, 32'h0, 1'b0);
    clock();
    check("status_ovf_clr", rdata, 32'h0000_0002);

    // Push into a full FIFO while popping
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1008, 32'h10 + 32'(i), 1'b0);
      clock();
    end
    drive(1'b1, 32'h1008, 32'h55, 1'b1);
    clock();
    drive(1'b0, 32'h100C, 32'h0, 1'b0);
    clock();
    check("status_push_pop_full", rdata, 32'h0000_0021);
    for (int i = 0; i < 7; i++) exp40[i] = 32'h11 + 32'(i);
    exp40[7] = 32'h55;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h2000, 32'h0, 1'b1);
      check("pushpop_seq", out_data, exp40[i]);
      clock();
    end

    // Reset with words queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1008, 32'hC0 + 32'(i), 1'b0);
      clock();
    end
    do_reset();
    drive(1'b0, 32'h100C, 32'h0, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'h0);
    clock();
    check("post_rst_status", rdata, 32'h0000_0002);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       a = $urandom_range(0, 255);
        1:       a = 32'h1000;
        2:       a = 32'h1004;
        3, 4:    a = 32'h1008;
        5:       a = 32'h100C;
        6:       a = 32'h1001 + 32'($urandom_range(0, 2)) * 32'h10;
        default: a = $urandom | 32'h8000_0000;
      endcase
      if (($urandom % 8) == 0) switches = 3'($urandom);
      if (n == 400) do_reset();
      drive(1'($urandom), a, $urandom, 1'($urandom_range(0, 2) == 0));
      clock();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_ctrl.md
DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sample-out FIFO depth in words; SHALL be a power of two, 2..16.
REQ-002 Parameter RAM_AW, default 10, external data-RAM word-address width.
REQ-003 Port clk  in  1  the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port mem_we  in  1  store strobe from the processor execute stage.
REQ-006 Port addr  in  32  byte address from the processor ALU output.
REQ-007 Port wdata  in  32  store data from the processor.
REQ-008 Port rdata  out  32  load data returned to the processor memory stage.
REQ-009 Port ram_addr  out  RAM_AW  word address to the external synchronous RAM.
REQ-010 Port ram_we  out  1  RAM write enable.
REQ-011 Port ram_wdata  out  32  RAM write data.
REQ-012 Port ram_rdata  in  32  RAM read data, valid one cycle after ram_addr.
REQ-013 Port leds  out  8  LED register contents.
REQ-014 Port switches  in  3  asynchronous board switches.
REQ-015 Port out_valid  out  1  sample FIFO is not empty.
REQ-016 Port out_data  out  32  sample FIFO head word.
REQ-017 Port out_ready  in  1  downstream sink accepts the head word.

Function
REQ-018 Address decode SHALL be: RAM 0x0000_0000-0x0000_0FFF; LED 0x1000; SW 0x1004; FIFO 0x1008; STATUS 0x100C; anything else unmapped.
REQ-019 ram_addr SHALL equal addr[RAM_AW+1:2]; ram_we SHALL equal mem_we AND RAM hit; ram_wdata SHALL equal wdata (all combinational).
REQ-020 A store to LED SHALL load wdata[7:0] into leds on the next edge.
REQ-021 switches SHALL pass through a 2-flop synchronizer; reads of SW SHALL return the synchronized value zero-extended.
REQ-022 A store to FIFO SHALL push wdata when not full, or when full with a pop in the same cycle.
REQ-023 A store to FIFO when full with no same-cycle pop SHALL drop the data and set the sticky overflow flag.
REQ-024 A pop SHALL occur when out_valid and out_ready are both high; out_data SHALL be the current head word.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 STATUS read SHALL return bit0 full, bit1 empty, bits[6:2] count, bit8 overflow, all other bits 0.
REQ-027 A store to STATUS with wdata[8]=1 SHALL clear overflow; if an overflow occurs in the same cycle, set SHALL win.
REQ-028 Read latency SHALL be 1 cycle: the region select and register snapshots are registered at the addr edge, and rdata selects ram_rdata or the snapshot.
REQ-029 LED, SW and STATUS values returned SHALL be those present before any same-cycle store.
REQ-030 Unmapped reads SHALL return 0; unmapped stores SHALL have no effect.
REQ-031 Reads SHALL have no side effects; STATUS is not cleared on read.

Reset
REQ-032 While reset=0: leds=0, FIFO empty (count 0, pointers 0), overflow=0, synchronizer flops=0, registered select=unmapped, rdata=0, out_valid=0.
REQ-033 Reset asserted mid-operation SHALL discard FIFO contents immediately; no pop or push SHALL occur in the release cycle if reset is still low at that edge.

Structure
REQ-034 Package bus_pkg SHALL hold the address constants, a region enum (RAM, LED, SW, FIFO, STATUS, NONE) and the STATUS bit positions.
REQ-035 The FIFO SHALL be a separate sub-module, sample_fifo, parameterised by depth, with push, pop, full, empty and count ports.
REQ-036 Target size: 120-400 lines of RTL.

Verification
REQ-037 Store 0xA5 to 0x1000, then load 0x1000 -> leds=0xA5 one cycle after the store; rdata=0x0000_00A5 one cycle after the load address.
REQ-038 switches=3'b101 held -> load 0x1004 issued at least 2 cycles later returns 0x0000_0005.
REQ-039 With out_ready=0, push 9 words 1..9 to 0x1008 -> STATUS=0x0000_0121 (full, count 8, overflow); then out_ready=1 -> out_data sequence 1..8, and STATUS reads 0x0000_0102 afterwards.
REQ-040 FIFO full with out_ready=1 and a push of 0x55 in the same cycle -> count stays 8, overflow stays 0, and 0x55 emerges after the 7 older words.
REQ-041 Store 0xDEAD_BEEF to 0x0000_0010, load 0x0000_0010 -> ram_we=1 with ram_addr=4; rdata=0xDEAD_BEEF in the load's memory-stage cycle; load 0x2000 -> rdata=0.
REQ-042 Drop reset to 0 with 3 words queued -> out_valid=0 and STATUS=0x0000_0002 immediately after release.
